// File: rtl/pa_core_trap_seq_if.sv
// CSR write-port bundle (address, strobe, data).
// master drives a write, slave receives it.
interface pa_core_trap_seq_if #(
    parameter int CSR_W  = 12,
    parameter int DATA_W = 32
);
    logic [CSR_W-1:0]  waddr;
    logic              wvld;
    logic [DATA_W-1:0] wdata;

    modport master (output waddr, output wvld, output wdata);
    modport slave  (input  waddr, input  wvld, input  wdata);
endinterface

// File: rtl/pa_core_trap_seq.sv
// Trap sequencer: owns the machine-mode CSR write port, runs trap-entry
// and mret sequences, stalls the pipeline while busy, then redirects.
// Ports: clk_i/rst_i (sync, active-high); exc_*/irq_*/mret_i requests;
//   inst_w (slave) instruction CSR write; csr_* live CSR values;
//   csr_w (master) CSR write port; stall_o; jmp_vld_o/jmp_pc_o redirect.
module pa_core_trap_seq #(
    parameter int DATA_W    = 32,
    parameter int CSR_W     = 12,
    parameter bit VECTOR_EN = 1'b0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              exc_req_i,
    input  logic [3:0]        exc_cause_i,
    input  logic [DATA_W-1:0] exc_pc_i,
    input  logic [DATA_W-1:0] exc_tval_i,
    input  logic              irq_ext_i,
    input  logic              irq_tmr_i,
    input  logic              irq_sw_i,
    input  logic [DATA_W-1:0] irq_pc_i,
    input  logic              mret_i,
    pa_core_trap_seq_if.slave  inst_w,
    input  logic [DATA_W-1:0] csr_mtvec_i,
    input  logic [DATA_W-1:0] csr_mepc_i,
    input  logic [DATA_W-1:0] csr_mstatus_i,
    input  logic [DATA_W-1:0] csr_mie_i,
    pa_core_trap_seq_if.master csr_w,
    output logic              stall_o,
    output logic              jmp_vld_o,
    output logic [DATA_W-1:0] jmp_pc_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_W_MEPC,
        S_W_MCAUSE,
        S_W_MTVAL,
        S_W_MSTAT_T,
        S_W_MSTAT_R,
        S_JUMP
    } state_t;

    localparam logic [CSR_W-1:0] A_MSTATUS = CSR_W'(12'h300);
    localparam logic [CSR_W-1:0] A_MEPC    = CSR_W'(12'h341);
    localparam logic [CSR_W-1:0] A_MCAUSE  = CSR_W'(12'h342);
    localparam logic [CSR_W-1:0] A_MTVAL   = CSR_W'(12'h343);

    state_t            r_state;
    state_t            w_nxt;
    logic [DATA_W-1:0] r_cause;
    logic [DATA_W-1:0] r_epc;
    logic [DATA_W-1:0] r_tval;
    logic              r_irq;
    logic              r_mret;

    logic [2:0]        w_pend;
    logic              w_irq;
    logic [3:0]        w_irq_code;
    logic [3:0]        w_c4;
    logic              w_acc_trap;
    logic              w_acc_mret;
    logic [DATA_W-1:0] w_mst_t;
    logic [DATA_W-1:0] w_mst_r;
    logic [DATA_W-1:0] w_base;
    logic [DATA_W-1:0] w_tgt;

    logic              w_stall;
    logic              w_wvld;
    logic [CSR_W-1:0]  w_waddr;
    logic [DATA_W-1:0] w_wdata;
    logic              w_jvld;
    logic [DATA_W-1:0] w_jpc;
    logic              w_unused;

    assign w_unused = ^csr_mie_i;

    // pending order is {ext, sw, tmr}, which is also the priority order
    assign w_pend = {irq_ext_i & csr_mie_i[11],
                     irq_sw_i  & csr_mie_i[3],
                     irq_tmr_i & csr_mie_i[7]};
    assign w_irq  = csr_mstatus_i[3] & (|w_pend);

    always_comb begin
        w_irq_code = 4'd7;
        if (w_pend[2])      w_irq_code = 4'd11;
        else if (w_pend[1]) w_irq_code = 4'd3;
    end

    assign w_c4       = exc_req_i ? exc_cause_i : w_irq_code;
    assign w_acc_trap = (r_state == S_IDLE) & (exc_req_i | w_irq);
    assign w_acc_mret = (r_state == S_IDLE) & ~w_acc_trap & mret_i;

    always_comb begin
        w_mst_t        = csr_mstatus_i;
        w_mst_t[7]     = csr_mstatus_i[3];
        w_mst_t[3]     = 1'b0;
        w_mst_t[12:11] = 2'b11;
        w_mst_r        = csr_mstatus_i;
        w_mst_r[3]     = csr_mstatus_i[7];
        w_mst_r[7]     = 1'b1;
        w_mst_r[12:11] = 2'b11;
    end

    // vectored mode only applies to interrupts
    assign w_base = csr_mtvec_i & ~DATA_W'(3);
    assign w_tgt  = (VECTOR_EN && r_irq && (csr_mtvec_i[1:0] == 2'b01))
                  ? w_base + {{(DATA_W-6){1'b0}}, r_cause[3:0], 2'b00}
                  : w_base;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
            r_cause <= '0;
            r_epc   <= '0;
            r_tval  <= '0;
            r_irq   <= 1'b0;
            r_mret  <= 1'b0;
        end else begin
            r_state <= w_nxt;
            if (w_acc_trap) begin
                r_cause <= {~exc_req_i, {(DATA_W-5){1'b0}}, w_c4};
                r_epc   <= exc_req_i ? exc_pc_i : irq_pc_i;
                r_tval  <= exc_req_i ? exc_tval_i : '0;
                r_irq   <= ~exc_req_i;
                r_mret  <= 1'b0;
            end else if (w_acc_mret) begin
                r_irq   <= 1'b0;
                r_mret  <= 1'b1;
            end
        end
    end

    always_comb begin
        w_nxt   = r_state;
        w_stall = 1'b0;
        w_wvld  = 1'b0;
        w_waddr = '0;
        w_wdata = '0;
        w_jvld  = 1'b0;
        w_jpc   = '0;
        unique case (r_state)
            S_IDLE: begin
                w_waddr = inst_w.waddr;
                w_wdata = inst_w.wdata;
                w_wvld  = inst_w.wvld;
                // an accepted trap or mret flushes the instruction's write
                if (w_acc_trap) begin
                    w_nxt   = S_W_MEPC;
                    w_stall = 1'b1;
                    w_wvld  = 1'b0;
                end else if (w_acc_mret) begin
                    w_nxt   = S_W_MSTAT_R;
                    w_stall = 1'b1;
                    w_wvld  = 1'b0;
                end
            end
            S_W_MEPC: begin
                w_stall = 1'b1;
                w_wvld  = 1'b1;
                w_waddr = A_MEPC;
                w_wdata = r_epc;
                w_nxt   = S_W_MCAUSE;
            end
            S_W_MCAUSE: begin
                w_stall = 1'b1;
                w_wvld  = 1'b1;
                w_waddr = A_MCAUSE;
                w_wdata = r_cause;
                w_nxt   = S_W_MTVAL;
            end
            S_W_MTVAL: begin
                w_stall = 1'b1;
                w_wvld  = 1'b1;
                w_waddr = A_MTVAL;
                w_wdata = r_tval;
                w_nxt   = S_W_MSTAT_T;
            end
            S_W_MSTAT_T: begin
                w_stall = 1'b1;
                w_wvld  = 1'b1;
                w_waddr = A_MSTATUS;
                w_wdata = w_mst_t;
                w_nxt   = S_JUMP;
            end
            S_W_MSTAT_R: begin
                w_stall = 1'b1;
                w_wvld  = 1'b1;
                w_waddr = A_MSTATUS;
                w_wdata = w_mst_r;
                w_nxt   = S_JUMP;
            end
            S_JUMP: begin
                w_stall = 1'b1;
                w_jvld  = 1'b1;
                w_jpc   = r_mret ? csr_mepc_i : w_tgt;
                w_nxt   = S_IDLE;
            end
            default: w_nxt = S_IDLE;
        endcase
        // reset silences the block in the very cycle it is asserted
        if (rst_i) begin
            w_stall = 1'b0;
            w_wvld  = 1'b0;
            w_waddr = '0;
            w_wdata = '0;
            w_jvld  = 1'b0;
            w_jpc   = '0;
        end
    end

    assign stall_o     = w_stall;
    assign csr_w.wvld  = w_wvld;
    assign csr_w.waddr = w_waddr;
    assign csr_w.wdata = w_wdata;
    assign jmp_vld_o   = w_jvld;
    assign jmp_pc_o    = w_jpc;

endmodule

// File: tb/tb_pa_core_trap_seq.sv
// Bench for pa_core_trap_seq: directed stimulus, per-cycle model compare
// plus literal checks of the hand-worked scenarios.
module tb_pa_core_trap_seq;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        exc_req_i;
    logic [3:0]  exc_cause_i;
    logic [31:0] exc_pc_i, exc_tval_i, irq_pc_i;
    logic        irq_ext_i, irq_tmr_i, irq_sw_i, mret_i;
    logic [31:0] mtvec, mepc, mstatus, mie;
    logic        stall_o, jmp_vld_o;
    logic [31:0] jmp_pc_o;

    int total = 0;
    int bad   = 0;
    bit run   = 1'b0;

    pa_core_trap_seq_if #(.CSR_W(12), .DATA_W(32)) u_inst_w ();
    pa_core_trap_seq_if #(.CSR_W(12), .DATA_W(32)) u_csr_w ();

    pa_core_trap_seq #(.DATA_W(32), .CSR_W(12), .VECTOR_EN(1'b1)) dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .exc_req_i     (exc_req_i),
        .exc_cause_i   (exc_cause_i),
        .exc_pc_i      (exc_pc_i),
        .exc_tval_i    (exc_tval_i),
        .irq_ext_i     (irq_ext_i),
        .irq_tmr_i     (irq_tmr_i),
        .irq_sw_i      (irq_sw_i),
        .irq_pc_i      (irq_pc_i),
        .mret_i        (mret_i),
        .inst_w        (u_inst_w),
        .csr_mtvec_i   (mtvec),
        .csr_mepc_i    (mepc),
        .csr_mstatus_i (mstatus),
        .csr_mie_i     (mie),
        .csr_w         (u_csr_w),
        .stall_o       (stall_o),
        .jmp_vld_o     (jmp_vld_o),
        .jmp_pc_o      (jmp_pc_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- model ----------------
    localparam int K_MEPC = 0, K_MCAUSE = 1, K_MTVAL = 2;
    localparam int K_MST_T = 3, K_MST_R = 4, K_JT = 5, K_JR = 6;

    typedef struct {
        int          k;
        logic [31:0] v;
        bit          irq;
    } step_t;

    step_t q[$];

    function automatic int irq_code();
        if (mstatus[3] == 1'b0)         return -1;
        if (irq_ext_i && mie[11])       return 11;
        if (irq_sw_i  && mie[3])        return 3;
        if (irq_tmr_i && mie[7])        return 7;
        return -1;
    endfunction

    function automatic void push_trap(int code, logic [31:0] pc,
                                      logic [31:0] tval, bit irq);
        step_t s;
        logic [31:0] cause;
        cause = code;
        if (irq) cause = cause + 32'h8000_0000;
        s.irq = irq;
        s.k = K_MEPC;   s.v = pc;    q.push_back(s);
        s.k = K_MCAUSE; s.v = cause; q.push_back(s);
        s.k = K_MTVAL;  s.v = tval;  q.push_back(s);
        s.k = K_MST_T;  s.v = 0;     q.push_back(s);
        s.k = K_JT;     s.v = code;  q.push_back(s);
    endfunction

    always @(negedge clk) if (run) begin
        logic        e_st, e_wv, e_jv;
        logic [31:0] e_wa, e_wd, e_jp, base;
        int          ic;
        step_t       s;
        e_st = 0; e_wv = 0; e_jv = 0;
        e_wa = 0; e_wd = 0; e_jp = 0;
        if (rst_i) begin
            q.delete();
        end else if (q.size() == 0) begin
            ic = irq_code();
            if (exc_req_i) begin
                e_st = 1;
                push_trap(int'(exc_cause_i), exc_pc_i, exc_tval_i, 1'b0);
            end else if (ic >= 0) begin
                e_st = 1;
                push_trap(ic, irq_pc_i, 32'h0, 1'b1);
            end else if (mret_i) begin
                e_st = 1;
                s.irq = 0; s.v = 0;
                s.k = K_MST_R; q.push_back(s);
                s.k = K_JR;    q.push_back(s);
            end else begin
                e_wv = u_inst_w.wvld;
                e_wa = 32'(u_inst_w.waddr);
                e_wd = u_inst_w.wdata;
            end
        end else begin
            s = q.pop_front();
            e_st = 1;
            case (s.k)
                K_MEPC:   begin e_wv = 1; e_wa = 32'h341; e_wd = s.v; end
                K_MCAUSE: begin e_wv = 1; e_wa = 32'h342; e_wd = s.v; end
                K_MTVAL:  begin e_wv = 1; e_wa = 32'h343; e_wd = s.v; end
                K_MST_T: begin
                    e_wv = 1; e_wa = 32'h300;
                    e_wd = (mstatus & ~32'h88) | ((mstatus & 32'h8) << 4)
                         | 32'h1800;
                end
                K_MST_R: begin
                    e_wv = 1; e_wa = 32'h300;
                    e_wd = (mstatus & ~32'h88) | ((mstatus >> 4) & 32'h8)
                         | 32'h1880;
                end
                K_JT: begin
                    e_jv = 1;
                    base = mtvec - (mtvec % 4);
                    if (s.irq && (mtvec % 4) == 1) e_jp = base + s.v * 4;
                    else                           e_jp = base;
                end
                default: begin e_jv = 1; e_jp = mepc; end
            endcase
        end
        chk("m_stall", 32'(stall_o), 32'(e_st));
        chk("m_wvld", 32'(u_csr_w.wvld), 32'(e_wv));
        if (e_wv) begin
            chk("m_waddr", 32'(u_csr_w.waddr), e_wa);
            chk("m_wdata", u_csr_w.wdata, e_wd);
        end
        chk("m_jvld", 32'(jmp_vld_o), 32'(e_jv));
        if (e_jv) chk("m_jpc", jmp_pc_o, e_jp);
    end

    // ---------------- stimulus ----------------
    task automatic nx();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    initial begin
        #200000;
        bad++;
        $display("FAIL timeout: got running want finished");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    initial begin
        rst_i = 1; exc_req_i = 0; exc_cause_i = 0; exc_pc_i = 0;
        exc_tval_i = 0; irq_pc_i = 0; irq_ext_i = 0; irq_tmr_i = 0;
        irq_sw_i = 0; mret_i = 0; mtvec = 0; mepc = 0; mstatus = 0;
        mie = 0;
        u_inst_w.wvld = 1; u_inst_w.waddr = 12'h340;
        u_inst_w.wdata = 32'h1234;
        run = 1;
        smp();
        chk("rst_wvld", 32'(u_csr_w.wvld), 0);
        chk("rst_stall", 32'(stall_o), 0);
        chk("rst_jvld", 32'(jmp_vld_o), 0);
        nx();
        rst_i = 0; u_inst_w.wvld = 0;

        // 1: exception
        mtvec = 32'h100;
        exc_req_i = 1; exc_cause_i = 2; exc_pc_i = 32'h80;
        exc_tval_i = 32'hDEAD;
        smp(); chk("t1_stall", 32'(stall_o), 1);
        nx(); exc_req_i = 0;
        smp(); chk("t1_mepc", u_csr_w.wdata, 32'h80);
        chk("t1_mepc_a", 32'(u_csr_w.waddr), 32'h341);
        nx(); smp(); chk("t1_mcause", u_csr_w.wdata, 32'h2);
        nx(); smp(); chk("t1_mtval", u_csr_w.wdata, 32'hDEAD);
        nx(); smp(); chk("t1_mst_a", 32'(u_csr_w.waddr), 32'h300);
        nx(); smp(); chk("t1_jvld", 32'(jmp_vld_o), 1);
        chk("t1_jpc", jmp_pc_o, 32'h100);
        nx(); smp(); chk("t1_idle", 32'(stall_o), 0);
        nx();

        // 2: vectored external interrupt, deasserts mid-sequence
        mstatus = 32'h08; mie = 32'h800; mtvec = 32'h201;
        irq_pc_i = 32'h90; irq_ext_i = 1;
        smp(); chk("t2_stall", 32'(stall_o), 1);
        nx(); irq_ext_i = 0;
        smp(); chk("t2_mepc", u_csr_w.wdata, 32'h90);
        nx(); smp(); chk("t2_mcause", u_csr_w.wdata, 32'h8000000B);
        nx(); smp(); chk("t2_mtval", u_csr_w.wdata, 32'h0);
        nx(); smp(); chk("t2_mst", u_csr_w.wdata, 32'h1880);
        nx(); smp(); chk("t2_jpc", jmp_pc_o, 32'h22C);
        nx();

        // 3: mret
        mstatus = 32'h1880; mepc = 32'h84; mie = 0; mret_i = 1;
        smp(); chk("t3_stall", 32'(stall_o), 1);
        nx(); mret_i = 0;
        smp(); chk("t3_mst", u_csr_w.wdata, 32'h1888);
        chk("t3_mst_a", 32'(u_csr_w.waddr), 32'h300);
        nx(); smp(); chk("t3_jpc", jmp_pc_o, 32'h84);
        chk("t3_jvld", 32'(jmp_vld_o), 1);
        nx();

        // 4: inst write dropped by trap, then forwarded alone
        mstatus = 0; mtvec = 32'h100;
        exc_req_i = 1; exc_cause_i = 4; exc_pc_i = 32'hA0; exc_tval_i = 0;
        u_inst_w.wvld = 1; u_inst_w.waddr = 12'h340; u_inst_w.wdata = 32'h55;
        smp(); chk("t4_drop", 32'(u_csr_w.wvld), 0);
        nx(); exc_req_i = 0; u_inst_w.wvld = 0;
        repeat (5) nx();
        u_inst_w.wvld = 1;
        smp(); chk("t4_fwd_v", 32'(u_csr_w.wvld), 1);
        chk("t4_fwd_a", 32'(u_csr_w.waddr), 32'h340);
        chk("t4_fwd_d", u_csr_w.wdata, 32'h55);
        chk("t4_fwd_st", 32'(stall_o), 0);
        nx(); u_inst_w.wvld = 0;

        // 5: masked irq ignored; exc beats irq; irq taken back-to-back
        mstatus = 0; mie = 32'h888; irq_tmr_i = 1; irq_pc_i = 32'hE0;
        smp(); chk("t5_mask", 32'(stall_o), 0);
        nx(); smp(); chk("t5_mask2", 32'(stall_o), 0);
        nx();
        mstatus = 32'h8; exc_req_i = 1; exc_cause_i = 5;
        exc_pc_i = 32'hB0; exc_tval_i = 32'h7;
        smp(); chk("t5_stall", 32'(stall_o), 1);
        nx(); exc_req_i = 0;
        nx(); smp(); chk("t5_cause", u_csr_w.wdata, 32'h5);
        nx(); nx(); nx();
        smp(); chk("t5_jpc", jmp_pc_o, 32'h100);
        nx();
        smp(); chk("t5_b2b", 32'(stall_o), 1);
        nx(); irq_tmr_i = 0;
        nx(); smp(); chk("t5_tcause", u_csr_w.wdata, 32'h80000007);
        repeat (4) nx();

        // 6: reset mid-trap aborts
        mstatus = 0; exc_req_i = 1; exc_cause_i = 1;
        exc_pc_i = 32'hC0; exc_tval_i = 32'h11;
        smp(); chk("t6_stall", 32'(stall_o), 1);
        nx(); exc_req_i = 0;
        smp(); chk("t6_mepc", u_csr_w.wdata, 32'hC0);
        nx(); rst_i = 1;
        smp(); chk("t6_rst_w", 32'(u_csr_w.wvld), 0);
        nx(); rst_i = 0;
        for (int i = 0; i < 6; i++) begin
            smp();
            chk("t6_no_w", 32'(u_csr_w.wvld), 0);
            chk("t6_no_j", 32'(jmp_vld_o), 0);
            chk("t6_no_st", 32'(stall_o), 0);
            nx();
        end

        run = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
